// File: rtl/decode_stage.sv
// decode_stage: Y86-64 style decode stage with integrated register file,
// operand forwarding and the D->E pipeline register.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   D_stat/icode/ifun/rA/rB       decode-stage instruction fields
//   D_valC, D_valP                constant and next PC
//   e_dstE/e_valE                 execute ALU forward
//   M_dstM/m_valM, M_dstE/M_valE  memory-stage forwards
//   W_dstM/W_valM, W_dstE/W_valE  writeback forwards and register-file write ports
//   E_bubble                      load a nop into the E register
//   d_srcA, d_srcB                combinational source register IDs
//   E_*                           registered execute-stage image
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  W_dstM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valM,
  input  logic [63:0] W_valE,
  input  logic        E_bubble,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [1:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_reg_t;

  localparam e_reg_t E_NOP = '{
    stat:  2'd0,
    icode: I_NOP,
    ifun:  4'h0,
    valC:  64'd0,
    valA:  64'd0,
    valB:  64'd0,
    dstE:  REG_NONE,
    dstM:  REG_NONE,
    srcA:  REG_NONE,
    srcB:  REG_NONE
  };

  logic [63:0] rf_q [15];
  logic [63:0] rf_d [15];
  e_reg_t      e_q;
  e_reg_t      e_d;

  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [63:0] rf_a;
  logic [63:0] rf_b;
  logic [63:0] val_a;
  logic [63:0] val_b;

  // Register ID decode
  always_comb begin
    d_srcA = REG_NONE;
    d_srcB = REG_NONE;
    dst_e  = REG_NONE;
    dst_m  = REG_NONE;

    case (D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
      I_RET, I_POPQ:                      d_srcA = REG_RSP;
      default:                            d_srcA = REG_NONE;
    endcase

    case (D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = REG_RSP;
      default:                            d_srcB = REG_NONE;
    endcase

    case (D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = REG_RSP;
      default:                            dst_e = REG_NONE;
    endcase

    case (D_icode)
      I_MRMOVQ, I_POPQ:                   dst_m = D_rA;
      default:                            dst_m = REG_NONE;
    endcase
  end

  // Register file write: dstM is applied last so it wins a same-ID collision
  always_comb begin
    rf_d = rf_q;
    if (W_dstE != REG_NONE) rf_d[W_dstE] = W_valE;
    if (W_dstM != REG_NONE) rf_d[W_dstM] = W_valM;
  end

  always_comb begin
    rf_a = (d_srcA == REG_NONE) ? '0 : rf_q[d_srcA];
    rf_b = (d_srcB == REG_NONE) ? '0 : rf_q[d_srcB];
  end

  // Operand selection; the W paths cover same-cycle write/read of one register
  always_comb begin
    if (D_icode == I_CALL || D_icode == I_JXX) val_a = D_valP;
    else if (d_srcA == REG_NONE)               val_a = '0;
    else if (d_srcA == e_dstE)                 val_a = e_valE;
    else if (d_srcA == M_dstM)                 val_a = m_valM;
    else if (d_srcA == M_dstE)                 val_a = M_valE;
    else if (d_srcA == W_dstM)                 val_a = W_valM;
    else if (d_srcA == W_dstE)                 val_a = W_valE;
    else                                       val_a = rf_a;

    if (d_srcB == REG_NONE)                    val_b = '0;
    else if (d_srcB == e_dstE)                 val_b = e_valE;
    else if (d_srcB == M_dstM)                 val_b = m_valM;
    else if (d_srcB == M_dstE)                 val_b = M_valE;
    else if (d_srcB == W_dstM)                 val_b = W_valM;
    else if (d_srcB == W_dstE)                 val_b = W_valE;
    else                                       val_b = rf_b;
  end

  always_comb begin
    e_d = E_NOP;
    if (!E_bubble) begin
      e_d.stat  = D_stat;
      e_d.icode = D_icode;
      e_d.ifun  = D_ifun;
      e_d.valC  = D_valC;
      e_d.valA  = val_a;
      e_d.valB  = val_b;
      e_d.dstE  = dst_e;
      e_d.dstM  = dst_m;
      e_d.srcA  = d_srcA;
      e_d.srcB  = d_srcB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q  <= E_NOP;
      rf_q <= '{default: '0};
    end else begin
      e_q  <= e_d;
      rf_q <= rf_d;
    end
  end

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.valC;
  assign E_valA  = e_q.valA;
  assign E_valB  = e_q.valB;
  assign E_dstE  = e_q.dstE;
  assign E_dstM  = e_q.dstM;
  assign E_srcA  = e_q.srcA;
  assign E_srcB  = e_q.srcB;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE;
  logic [63:0] e_valE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic [3:0]  M_dstE;
  logic [63:0] M_valE;
  logic [3:0]  W_dstM, W_dstE;
  logic [63:0] W_valM, W_valE;
  logic        E_bubble;
  logic [3:0]  d_srcA, d_srcB;
  logic [1:0]  E_stat;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .W_dstM(W_dstM), .W_dstE(W_dstE), .W_valM(W_valM), .W_valE(W_valE),
    .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mrf [15];
  logic [1:0]  x_stat;
  logic [3:0]  x_icode, x_ifun, x_dstE, x_dstM, x_srcA, x_srcB;
  logic [63:0] x_valC, x_valA, x_valB;

  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) return ra;
    if (ic == 4'h9 || ic == 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) return rb;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic == 4'h2 || ic == 4'h3 || ic == 4'h6) return rb;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction

  // First producer in pipeline order that targets src; else register-file contents
  function automatic logic [63:0] m_resolve(input logic [3:0] src);
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    if (src == 4'hF) return 64'd0;
    ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    foreach (ids[i]) if (ids[i] == src) return vals[i];
    return mrf[src];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_stat <= 2'd0; x_icode <= 4'h1; x_ifun <= 4'h0;
      x_valC <= 64'd0; x_valA <= 64'd0; x_valB <= 64'd0;
      x_dstE <= 4'hF; x_dstM <= 4'hF; x_srcA <= 4'hF; x_srcB <= 4'hF;
      mrf <= '{default: 64'd0};
    end else begin
      if (E_bubble) begin
        x_stat <= 2'd0; x_icode <= 4'h1; x_ifun <= 4'h0;
        x_valC <= 64'd0; x_valA <= 64'd0; x_valB <= 64'd0;
        x_dstE <= 4'hF; x_dstM <= 4'hF; x_srcA <= 4'hF; x_srcB <= 4'hF;
      end else begin
        x_stat  <= D_stat;
        x_icode <= D_icode;
        x_ifun  <= D_ifun;
        x_valC  <= D_valC;
        x_srcA  <= m_srcA(D_icode, D_rA);
        x_srcB  <= m_srcB(D_icode, D_rB);
        x_dstE  <= m_dstE(D_icode, D_rB);
        x_dstM  <= m_dstM(D_icode, D_rA);
        x_valA  <= (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP
                                                         : m_resolve(m_srcA(D_icode, D_rA));
        x_valB  <= m_resolve(m_srcB(D_icode, D_rB));
      end
      if (W_dstE != 4'hF) mrf[W_dstE] <= W_valE;
      if (W_dstM != 4'hF) mrf[W_dstM] <= W_valM;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d_srcA", {60'd0, d_srcA}, {60'd0, m_srcA(D_icode, D_rA)});
      chk("d_srcB", {60'd0, d_srcB}, {60'd0, m_srcB(D_icode, D_rB)});
      chk("E_stat",  {62'd0, E_stat},  {62'd0, x_stat});
      chk("E_icode", {60'd0, E_icode}, {60'd0, x_icode});
      chk("E_ifun",  {60'd0, E_ifun},  {60'd0, x_ifun});
      chk("E_valC",  E_valC, x_valC);
      chk("E_valA",  E_valA, x_valA);
      chk("E_valB",  E_valB, x_valB);
      chk("E_dstE",  {60'd0, E_dstE}, {60'd0, x_dstE});
      chk("E_dstM",  {60'd0, E_dstM}, {60'd0, x_dstM});
      chk("E_srcA",  {60'd0, E_srcA}, {60'd0, x_srcA});
      chk("E_srcB",  {60'd0, E_srcB}, {60'd0, x_srcB});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    D_stat = 2'd0; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = 64'd0; D_valP = 64'd0;
    e_dstE = 4'hF; e_valE = 64'd0;
    M_dstM = 4'hF; m_valM = 64'd0;
    M_dstE = 4'hF; M_valE = 64'd0;
    W_dstM = 4'hF; W_valM = 64'd0;
    W_dstE = 4'hF; W_valE = 64'd0;
    E_bubble = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rid();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r < 2) return 4'hF;
    if (r == 2) return 4'($urandom_range(0, 14));
    return 4'($urandom_range(0, 5));
  endfunction

  function automatic logic [63:0] r64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_E_icode", {60'd0, E_icode}, 64'd1);
    chk("rst_E_dstE",  {60'd0, E_dstE},  64'hF);
    chk("rst_E_valA",  E_valA, 64'd0);
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // all registers read 0 after reset
    for (int r = 0; r < 15; r++) begin
      idle(); D_icode = 4'h6; D_rA = 4'(r); D_rB = 4'(r);
      step();
      chk("rst_reg_read", E_valA, 64'd0);
    end

    // write then read
    idle(); W_dstE = 4'd3; W_valE = 64'd5;
    step();
    idle(); D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd3;
    step();
    chk("wr_rd_valA", E_valA, 64'd5);
    chk("wr_rd_valB", E_valB, 64'd5);
    chk("wr_rd_dstE", {60'd0, E_dstE}, 64'd3);

    // forward priority
    idle(); D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'd1;
    e_dstE = 4'd2; e_valE = 64'hAA; M_dstE = 4'd2; M_valE = 64'hBB;
    W_dstE = 4'd2; W_valE = 64'hCC;
    step();
    chk("fwd_prio_valA", E_valA, 64'hAA);

    // same-cycle write and read via W path
    idle(); D_icode = 4'h6; D_rA = 4'd9; D_rB = 4'd9; W_dstM = 4'd9; W_valM = 64'h1234;
    step();
    chk("w_bypass_valA", E_valA, 64'h1234);

    // call
    idle(); W_dstE = 4'd4; W_valE = 64'h100;
    step();
    idle(); D_icode = 4'h8; D_valP = 64'h20;
    #1;
    chk("call_d_srcA", {60'd0, d_srcA}, 64'hF);
    step();
    chk("call_valA", E_valA, 64'h20);
    chk("call_valB", E_valB, 64'h100);
    chk("call_srcB", {60'd0, E_srcB}, 64'd4);
    chk("call_dstE", {60'd0, E_dstE}, 64'd4);

    // bubble then popq
    idle(); D_icode = 4'hB; D_rA = 4'd5; E_bubble = 1'b1;
    step();
    chk("bub_icode", {60'd0, E_icode}, 64'd1);
    chk("bub_dstM",  {60'd0, E_dstM},  64'hF);
    E_bubble = 1'b0;
    step();
    chk("pop_icode", {60'd0, E_icode}, 64'hB);
    chk("pop_dstE",  {60'd0, E_dstE},  64'd4);
    chk("pop_dstM",  {60'd0, E_dstM},  64'd5);

    // dual write, M wins
    idle(); W_dstE = 4'd7; W_dstM = 4'd7; W_valE = 64'd1; W_valM = 64'd2;
    step();
    idle(); D_icode = 4'h6; D_rA = 4'd7; D_rB = 4'd7;
    step();
    chk("dual_wr_valA", E_valA, 64'd2);

    // randomized traffic with occasional asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      D_stat   = 2'($urandom_range(0, 3));
      D_icode  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                             : 4'($urandom_range(0, 11));
      D_ifun   = 4'($urandom_range(0, 15));
      D_rA     = rid();
      D_rB     = rid();
      D_valC   = r64();
      D_valP   = r64();
      e_dstE   = rid(); e_valE = r64();
      M_dstM   = rid(); m_valM = r64();
      M_dstE   = rid(); M_valE = r64();
      W_dstM   = rid(); W_valM = r64();
      W_dstE   = rid(); W_valE = r64();
      E_bubble = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_icode", {60'd0, E_icode}, 64'd1);
        chk("mid_rst_valA",  E_valA, 64'd0);
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed in REQ-002 to REQ-016.
REQ-002 clk  in  1  rising-edge clock for the register file and the E pipeline register.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 D_stat  in  2  decode-stage status (0 AOK, 1 HLT, 2 ADR, 3 INS).
REQ-005 D_icode, D_ifun, D_rA, D_rB  in  4 each  decode-stage instruction fields.
REQ-006 D_valC, D_valP  in  64 each  decode-stage constant and next PC.
REQ-007 e_dstE  in  4; e_valE  in  64  execute-stage ALU result forward.
REQ-008 M_dstM  in  4; m_valM  in  64  memory-stage load-data forward.
REQ-009 M_dstE  in  4; M_valE  in  64  memory-stage ALU forward.
REQ-010 W_dstM, W_dstE  in  4 each; W_valM, W_valE  in  64 each  writeback forward and register-file write ports.
REQ-011 E_bubble  in  1  load a nop into the E register at the next edge.
REQ-012 d_srcA, d_srcB  out  4 each  combinational source IDs for the hazard unit.
REQ-013 E_stat  out  2; E_icode, E_ifun  out  4 each  registered status and instruction fields.
REQ-014 E_valC, E_valA, E_valB  out  64 each  registered operands.
REQ-015 E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered register IDs.
REQ-016 Register ID 0xF SHALL mean "none"; ID 4 is %rsp.

Function
REQ-017 Opcodes SHALL be: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
REQ-018 d_srcA SHALL be D_rA for 2/4/6/A, 4 for 9/B, else 0xF.
REQ-019 d_srcB SHALL be D_rB for 4/5/6, 4 for 8/9/A/B, else 0xF.
REQ-020 dstE SHALL be D_rB for 2/3/6, 4 for 8/9/A/B, else 0xF.
REQ-021 dstM SHALL be D_rA for 5/B, else 0xF.
REQ-022 The register file SHALL hold 15 registers of 64 bits (IDs 0-14) with combinational reads; reading ID 0xF SHALL return 0.
REQ-023 On each rising edge, W_valE SHALL be written to reg[W_dstE] and W_valM to reg[W_dstM], each only if its ID is not 0xF.
REQ-024 If W_dstE equals W_dstM (not 0xF), W_valM SHALL win the write.
REQ-025 valA for icode 7 or 8 SHALL be D_valP.
REQ-026 Otherwise, valA and valB SHALL be selected by priority, first match against d_srcA/d_srcB (never on 0xF): e_dstE, M_dstM, M_dstE, W_dstM, W_dstE, then register file.
REQ-027 At each rising edge with E_bubble=0, the E register SHALL capture D_stat, D_icode, D_ifun, D_valC, the resolved valA and valB, dstE, dstM, d_srcA and d_srcB.
REQ-028 With E_bubble=1, the E register SHALL load the nop image: stat 0, icode 1, ifun 0, valC/valA/valB 0, dst and src IDs 0xF.
REQ-029 Latency from the D_* inputs to the E_* outputs SHALL be exactly one cycle; the d_src* outputs SHALL be combinational with zero latency.
REQ-030 The stage SHALL forward D_stat unchanged and SHALL NOT alter it.
REQ-031 A register-file write and a same-cycle read of the same ID SHALL return the new value through the W forwarding path.

Reset
REQ-032 While rst_n=0, asynchronously, the E register SHALL hold the nop image of REQ-028 and all 15 registers SHALL be 0.
REQ-033 Assertion of rst_n mid-operation SHALL discard the instruction in flight.
REQ-034 The first edge after rst_n rises SHALL capture normally.

Verification
REQ-035 Reset: assert rst_n=0 at an arbitrary time -> E_icode=1, E_dstE=0xF, E_valA=0 immediately; reg[0..14] read 0.
REQ-036 Write then read: cycle 1 W_dstE=3, W_valE=5; cycle 2 D OPq with rA=3, rB=3, no forwards -> E_valA=5, E_valB=5, E_dstE=3.
REQ-037 Forward priority: D OPq with rA=2, e_dstE=2 e_valE=0xAA, M_dstE=2 M_valE=0xBB, W_dstE=2 -> E_valA=0xAA.
REQ-038 Call: D_icode=8, D_valP=0x20, reg4=0x100 -> E_valA=0x20, E_valB=0x100, E_srcB=4, E_dstE=4, d_srcA=0xF.
REQ-039 Bubble: D popq with E_bubble=1 -> E_icode=1, E_dstM=0xF; next edge with E_bubble=0 -> E_icode=0xB, E_dstE=4, E_dstM=rA.
REQ-040 Dual write: W_dstE=W_dstM=7, W_valE=1, W_valM=2 -> a subsequent read of reg7 returns 2.
